// File: rtl/axi_nttw_s.sv
// AXI4 responder backed by a simple-dual-port RAM: stores write bursts and returns them on reads.
// Write and read paths are independent FSMs, each with one outstanding transaction.
module axi_nttw_s #(
  parameter int DATA_W = 128,
  parameter int ID_W   = 2,
  parameter int MEM_AW = 10
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [63:0]           awaddr,
  input  logic [ID_W-1:0]       awid,
  input  logic [7:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wlast,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [ID_W-1:0]       bid,
  output logic [1:0]            bresp,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [63:0]           araddr,
  input  logic [ID_W-1:0]       arid,
  input  logic [7:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_W-1:0]     rdata,
  output logic [ID_W-1:0]       rid,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic [31:0]           wr_cnt,
  output logic [31:0]           rd_cnt
);

  localparam int OFS    = $clog2(DATA_W / 8);
  localparam int STRB_W = DATA_W / 8;
  localparam int DEPTH  = 1 << MEM_AW;
  localparam logic [2:0] SIZE_OK     = 3'(OFS);
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} rstate_t;

  function automatic logic burst_legal(input logic [1:0] burst, input logic [2:0] size);
    return (burst == BURST_INCR) && (size == SIZE_OK);
  endfunction

  wstate_t wstate_r, wstate_nxt_s;
  rstate_t rstate_r, rstate_nxt_s;

  logic              awready_s, wready_s, bvalid_s, arready_s, rvalid_s;
  logic              aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
  logic              wlast_err_s, mem_we_s, unused_s;

  logic [ID_W-1:0]   wid_r, rid_r;
  logic [7:0]        wlen_r, wbeat_r, rlen_r, rbeat_r;
  logic [MEM_AW-1:0] widx_r, ridx_r;
  logic              wlegal_r, werr_r, rlegal_r, rlast_r;
  logic [1:0]        bresp_r, rresp_r;
  logic [DATA_W-1:0] rdata_r;
  logic [31:0]       wr_cnt_r, rd_cnt_r;
  logic [DATA_W-1:0] mem_r [DEPTH];

  assign aw_hs_s     = awvalid && awready_s;
  assign w_hs_s      = wvalid && wready_s;
  assign b_hs_s      = bvalid_s && bready;
  assign ar_hs_s     = arvalid && arready_s;
  assign r_hs_s      = rvalid_s && rready;
  assign wlast_err_s = wlast != (wbeat_r == wlen_r);
  assign mem_we_s    = w_hs_s && wlegal_r && !areset;
  assign unused_s    = ^{awaddr[63:MEM_AW+OFS], awaddr[OFS-1:0], araddr[63:MEM_AW+OFS], araddr[OFS-1:0]};

  // write FSM state register
  always_ff @(posedge aclk) begin
    if (areset) wstate_r <= W_IDLE;
    else        wstate_r <= wstate_nxt_s;
  end

  // write FSM next state
  always_comb begin
    wstate_nxt_s = wstate_r;
    case (wstate_r)
      W_IDLE:  if (awvalid) wstate_nxt_s = W_DATA; else wstate_nxt_s = W_IDLE;
      W_DATA:  if (wvalid && (wbeat_r == wlen_r)) wstate_nxt_s = W_RESP; else wstate_nxt_s = W_DATA;
      W_RESP:  if (bready) wstate_nxt_s = W_IDLE; else wstate_nxt_s = W_RESP;
      default: wstate_nxt_s = W_IDLE;
    endcase
  end

  // write FSM outputs
  always_comb begin
    awready_s = 1'b0;
    wready_s  = 1'b0;
    bvalid_s  = 1'b0;
    case (wstate_r)
      W_IDLE:  awready_s = 1'b1;
      W_DATA:  wready_s  = 1'b1;
      W_RESP:  bvalid_s  = 1'b1;
      default: awready_s = 1'b0;
    endcase
  end

  // write channel datapath; the response is decided on the final beat so B carries it one cycle later
  always_ff @(posedge aclk) begin
    if (areset) begin
      wid_r    <= {ID_W{1'b0}};
      wlen_r   <= 8'd0;
      wbeat_r  <= 8'd0;
      widx_r   <= {MEM_AW{1'b0}};
      wlegal_r <= 1'b0;
      werr_r   <= 1'b0;
      bresp_r  <= RESP_OKAY;
      wr_cnt_r <= 32'd0;
    end else if (aw_hs_s) begin
      wid_r    <= awid;
      wlen_r   <= awlen;
      wbeat_r  <= 8'd0;
      widx_r   <= awaddr[MEM_AW+OFS-1:OFS];
      wlegal_r <= burst_legal(awburst, awsize);
      werr_r   <= 1'b0;
    end else if (w_hs_s) begin
      werr_r <= werr_r | wlast_err_s;
      if (wbeat_r == wlen_r) begin
        bresp_r <= (!wlegal_r || werr_r || wlast_err_s) ? RESP_SLVERR : RESP_OKAY;
      end else begin
        wbeat_r <= wbeat_r + 8'd1;
        widx_r  <= widx_r + MEM_AW'(1);
      end
    end else if (b_hs_s) begin
      wr_cnt_r <= wr_cnt_r + 32'd1;
    end
  end

  // RAM write port, byte-lane masked
  always_ff @(posedge aclk) begin
    if (mem_we_s) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem_r[widx_r][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // read FSM state register
  always_ff @(posedge aclk) begin
    if (areset) rstate_r <= R_IDLE;
    else        rstate_r <= rstate_nxt_s;
  end

  // read FSM next state
  always_comb begin
    rstate_nxt_s = rstate_r;
    case (rstate_r)
      R_IDLE:  if (arvalid) rstate_nxt_s = R_FETCH; else rstate_nxt_s = R_IDLE;
      R_FETCH: rstate_nxt_s = R_DATA;
      R_DATA: begin
        if (rready) begin
          if (rlast_r) rstate_nxt_s = R_IDLE;
          else         rstate_nxt_s = R_FETCH;
        end else begin
          rstate_nxt_s = R_DATA;
        end
      end
      default: rstate_nxt_s = R_IDLE;
    endcase
  end

  // read FSM outputs
  always_comb begin
    arready_s = 1'b0;
    rvalid_s  = 1'b0;
    case (rstate_r)
      R_IDLE:  arready_s = 1'b1;
      R_FETCH: rvalid_s  = 1'b0;
      R_DATA:  rvalid_s  = 1'b1;
      default: arready_s = 1'b0;
    endcase
  end

  // read channel datapath; the RAM read in R_FETCH sees pre-write contents (read-first)
  always_ff @(posedge aclk) begin
    if (areset) begin
      rid_r    <= {ID_W{1'b0}};
      rlen_r   <= 8'd0;
      rbeat_r  <= 8'd0;
      ridx_r   <= {MEM_AW{1'b0}};
      rlegal_r <= 1'b0;
      rlast_r  <= 1'b0;
      rresp_r  <= RESP_OKAY;
      rdata_r  <= {DATA_W{1'b0}};
      rd_cnt_r <= 32'd0;
    end else if (ar_hs_s) begin
      rid_r    <= arid;
      rlen_r   <= arlen;
      rbeat_r  <= 8'd0;
      ridx_r   <= araddr[MEM_AW+OFS-1:OFS];
      rlegal_r <= burst_legal(arburst, arsize);
    end else if (rstate_r == R_FETCH) begin
      rdata_r <= rlegal_r ? mem_r[ridx_r] : {DATA_W{1'b0}};
      rresp_r <= rlegal_r ? RESP_OKAY : RESP_SLVERR;
      rlast_r <= (rbeat_r == rlen_r);
    end else if (r_hs_s) begin
      if (rlast_r) begin
        rd_cnt_r <= rd_cnt_r + 32'd1;
      end else begin
        rbeat_r <= rbeat_r + 8'd1;
        ridx_r  <= ridx_r + MEM_AW'(1);
      end
    end
  end

  assign awready = awready_s;
  assign wready  = wready_s;
  assign bvalid  = bvalid_s;
  assign bid     = wid_r;
  assign bresp   = bresp_r;
  assign arready = arready_s;
  assign rvalid  = rvalid_s;
  assign rdata   = rdata_r;
  assign rid     = rid_r;
  assign rresp   = rresp_r;
  assign rlast   = rlast_r;
  assign wr_cnt  = wr_cnt_r;
  assign rd_cnt  = rd_cnt_r;

endmodule

// File: tb/tb_axi_nttw_s.sv
// Directed bench for axi_nttw_s: a word model of the RAM feeds a queue of expected read beats.
module tb_axi_nttw_s;
  localparam int DW = 128;
  localparam int IW = 2;
  localparam int AW = 10;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          awvalid = 1'b0, awready;
  logic [63:0]   awaddr = 64'd0;
  logic [IW-1:0] awid = 2'd0;
  logic [7:0]    awlen = 8'd0;
  logic [2:0]    awsize = 3'd0;
  logic [1:0]    awburst = 2'd0;
  logic          wvalid = 1'b0, wready;
  logic [DW-1:0] wdata = '0;
  logic [15:0]   wstrb = 16'd0;
  logic          wlast = 1'b0;
  logic          bvalid, bready = 1'b0;
  logic [IW-1:0] bid;
  logic [1:0]    bresp;
  logic          arvalid = 1'b0, arready;
  logic [63:0]   araddr = 64'd0;
  logic [IW-1:0] arid = 2'd0;
  logic [7:0]    arlen = 8'd0;
  logic [2:0]    arsize = 3'd0;
  logic [1:0]    arburst = 2'd0;
  logic          rvalid, rready = 1'b0;
  logic [DW-1:0] rdata;
  logic [IW-1:0] rid;
  logic [1:0]    rresp;
  logic          rlast;
  logic [31:0]   wr_cnt, rd_cnt;

  axi_nttw_s #(.DATA_W(DW), .ID_W(IW), .MEM_AW(AW)) dut (
    .aclk(aclk), .areset(areset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast),
    .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [DW-1:0] d;
    logic [1:0]    resp;
    logic          last;
  } rexp_t;

  int            total = 0;
  int            bad = 0;
  int            exp_wr = 0;
  int            exp_rd = 0;
  logic [DW-1:0] mdl [int];
  logic [DW-1:0] wd_q [$];
  logic [15:0]   ws_q [$];
  logic          wl_q [$];
  rexp_t         sb_q [$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // queue n write beats base, base+1, ...; wlast on beat last_at (or the true last beat when -1)
  task automatic load_w(input int n, input logic [DW-1:0] base, input logic [15:0] strb, input int last_at);
    wd_q.delete(); ws_q.delete(); wl_q.delete();
    for (int b = 0; b < n; b++) begin
      wd_q.push_back(base + DW'(b));
      ws_q.push_back(strb);
      wl_q.push_back((last_at >= 0) ? (b == last_at) : (b == n - 1));
    end
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [1:0] id, input int len,
                          input logic [1:0] burst, input logic [1:0] exp_resp);
    int            n;
    bit            legal;
    logic [AW-1:0] idx;
    logic [DW-1:0] cur;
    legal = (burst == 2'b01);
    idx = addr[AW+3:4];
    @(negedge aclk);
    awvalid = 1'b1; awaddr = addr; awid = id; awlen = 8'(len); awsize = 3'd4; awburst = burst;
    n = 0;
    while (!awready && n < 50) begin @(negedge aclk); n++; end
    chk("aw_wait", 32'(n < 50), 32'd1);
    @(negedge aclk);
    awvalid = 1'b0;
    chk("awready_busy", 32'(awready), 32'd0);
    chk("wready_c1", 32'(wready), 32'd1);
    for (int b = 0; b <= len; b++) begin
      wvalid = 1'b1; wdata = wd_q[b]; wstrb = ws_q[b]; wlast = wl_q[b];
      if (legal) begin
        if (!mdl.exists(int'(idx))) mdl[int'(idx)] = '0;
        cur = mdl[int'(idx)];
        for (int k = 0; k < 16; k++) if (ws_q[b][k]) cur[8*k +: 8] = wd_q[b][8*k +: 8];
        mdl[int'(idx)] = cur;
      end
      @(negedge aclk);
      idx = idx + 10'd1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid_n1", 32'(bvalid), 32'd1);
    chk("bresp", 32'(bresp), 32'(exp_resp));
    chk("bid", 32'(bid), 32'(id));
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    exp_wr++;
    chk("bvalid_drop", 32'(bvalid), 32'd0);
    chk("awready_back", 32'(awready), 32'd1);
    chk("wr_cnt", 32'(wr_cnt), 32'(exp_wr));
  endtask

  // throttle=1 holds rready high only every third cycle so each beat sits stalled first
  task automatic do_read(input logic [63:0] addr, input logic [1:0] id, input int len,
                         input logic [1:0] burst, input bit throttle);
    int            n;
    bit            legal, done, held;
    logic [AW-1:0] idx;
    logic [DW+4:0] held_v;
    rexp_t         e;
    legal = (burst == 2'b01);
    idx = addr[AW+3:4];
    for (int b = 0; b <= len; b++) begin
      e.d    = legal ? mdl[int'(idx)] : '0;
      e.resp = legal ? 2'b00 : 2'b10;
      e.last = (b == len);
      sb_q.push_back(e);
      idx = idx + 10'd1;
    end
    @(negedge aclk);
    arvalid = 1'b1; araddr = addr; arid = id; arlen = 8'(len); arsize = 3'd4; arburst = burst;
    n = 0;
    while (!arready && n < 50) begin @(negedge aclk); n++; end
    chk("ar_wait", 32'(n < 50), 32'd1);
    @(negedge aclk);
    arvalid = 1'b0;
    chk("rvalid_c1", 32'(rvalid), 32'd0);
    chk("arready_busy", 32'(arready), 32'd0);
    n = 0; done = 1'b0; held = 1'b0; held_v = '0;
    while (!done && n < 200) begin
      rready = throttle ? ((n % 3) == 2) : 1'b1;
      if (held) begin
        chk("r_held_valid", 32'(rvalid), 32'd1);
        chk("r_stable", {rdata, rresp, rid, rlast}, held_v);
      end
      if (rvalid && rready) begin
        held = 1'b0;
        if (sb_q.size() == 0) begin
          chk("r_extra_beat", 32'd1, 32'd0);
          done = 1'b1;
        end else begin
          e = sb_q.pop_front();
          chk("rdata", rdata, e.d);
          chk("rresp", 32'(rresp), 32'(e.resp));
          chk("rid", 32'(rid), 32'(id));
          chk("rlast", 32'(rlast), 32'(e.last));
          if (e.last) done = 1'b1;
        end
      end else if (rvalid) begin
        held = 1'b1;
        held_v = {rdata, rresp, rid, rlast};
      end else begin
        held = 1'b0;
      end
      @(negedge aclk);
      n++;
    end
    rready = 1'b0;
    chk("r_done", 32'(done), 32'd1);
    if (!throttle) chk("r_thruput", 32'(n), 32'(2 * (len + 1)));
    exp_rd++;
    chk("arready_back", 32'(arready), 32'd1);
    chk("rd_cnt", 32'(rd_cnt), 32'(exp_rd));
  endtask

  initial begin
    int n;
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    chk("rst_awready", 32'(awready), 32'd1);
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_valids", {wready, bvalid, rvalid, rlast}, 4'h0);
    chk("rst_payload", {rdata, rresp, rid, bresp, bid}, '0);
    chk("rst_cnt", {wr_cnt, rd_cnt}, 64'd0);

    // basic INCR burst
    load_w(4, 128'd1, 16'hFFFF, -1);
    do_write(64'h40, 2'd1, 3, 2'b01, 2'b00);
    do_read(64'h40, 2'd2, 3, 2'b01, 1'b0);

    // partial strobe merges into the previous word contents
    load_w(1, {DW{1'b1}}, 16'hFFFF, -1);
    do_write(64'h100, 2'd3, 0, 2'b01, 2'b00);
    load_w(1, '0, 16'h0001, -1);
    do_write(64'h100, 2'd0, 0, 2'b01, 2'b00);
    do_read(64'h100, 2'd1, 0, 2'b01, 1'b0);
    chk("partial_lowbyte", 32'(rdata[7:0] === 8'h00 && rdata[127:8] === {120{1'b1}}), 32'd1);

    // illegal bursts: WRAP write leaves RAM untouched, FIXED read returns zeros with SLVERR
    load_w(2, 128'hAA, 16'hFFFF, -1);
    do_write(64'h40, 2'd2, 1, 2'b10, 2'b10);
    do_read(64'h40, 2'd3, 3, 2'b01, 1'b0);
    do_read(64'h40, 2'd0, 2, 2'b00, 1'b0);

    // early wlast: all beats taken, data written, SLVERR; low address bits ignored
    load_w(4, 128'h500, 16'hFFFF, 1);
    do_write(64'h207, 2'd1, 3, 2'b01, 2'b10);
    do_read(64'h200, 2'd1, 3, 2'b01, 1'b0);

    // index wrap past the top of RAM, read with throttled rready
    load_w(4, 128'h900, 16'hFFFF, -1);
    do_write(64'h3FE0, 2'd2, 3, 2'b01, 2'b00);
    do_read(64'h3FE0, 2'd2, 3, 2'b01, 1'b1);
    do_read(64'h0, 2'd3, 1, 2'b01, 1'b1);

    // reset in the middle of a write burst
    @(negedge aclk);
    awvalid = 1'b1; awaddr = 64'h800; awid = 2'd1; awlen = 8'd3; awsize = 3'd4; awburst = 2'b01;
    n = 0;
    while (!awready && n < 50) begin @(negedge aclk); n++; end
    @(negedge aclk);
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 128'h1234; wstrb = 16'hFFFF; wlast = 1'b0;
    repeat (2) @(negedge aclk);
    wvalid = 1'b0;
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    chk("mid_rst_awready", 32'(awready), 32'd1);
    chk("mid_rst_bvalid", 32'(bvalid), 32'd0);
    chk("mid_rst_wready", 32'(wready), 32'd0);
    chk("mid_rst_cnt", {wr_cnt, rd_cnt}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      chk("mid_rst_no_b", 32'(bvalid), 32'd0);
    end
    exp_wr = 0;
    exp_rd = 0;
    load_w(1, 128'h77, 16'hFFFF, -1);
    do_write(64'h40, 2'd3, 0, 2'b01, 2'b00);
    do_read(64'h40, 2'd3, 0, 2'b01, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
